// File: rtl/lut_voice_sched_pkg.sv
// Shared types for the LUT voice scheduler.
// State encoding and index-width helper.
package lut_voice_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lut_voice_sched.sv
// Time-multiplexes one LUT read port across NV voices
// and gates table writes to the gaps between rounds.
module lut_voice_sched
  import lut_voice_sched_pkg::*;
#(
  parameter int NV    = 4,
  parameter int WW    = 12,
  parameter int DEPTH = 128,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           samp_tick,
  input  logic [NV*AW-1:0] ph_addr,
  input  logic           prog_valid,
  input  logic [AW-1:0]  prog_addr,
  input  logic [WW-1:0]  prog_data,
  output logic           prog_ready,
  output logic           lut_re,
  output logic [AW-1:0]  lut_ra,
  output logic           lut_we,
  output logic [AW-1:0]  lut_wa,
  output logic [WW-1:0]  lut_wd,
  input  logic [WW-1:0]  lut_rd,
  output logic [NV*WW-1:0] voice_data,
  output logic           voice_valid,
  output logic           busy,
  output logic           overrun
);

  localparam int IW = idx_w(NV);
  localparam logic [IW-1:0] LAST = IW'(NV - 1);

  state_t          st, st_n;
  logic [IW-1:0]   idx, idx_n;
  logic [IW-1:0]   cap_idx;
  logic            cap_en;
  logic            snap_ld;
  logic [AW-1:0]   snap [NV];
  logic [NV*WW-1:0] vd;

  // Next-state and per-state outputs.
  always_comb begin
    st_n        = st;
    idx_n       = idx;
    snap_ld     = 1'b0;
    lut_re      = 1'b0;
    busy        = 1'b0;
    prog_ready  = 1'b0;
    voice_valid = 1'b0;
    unique case (st)
      S_IDLE, S_DONE: begin
        prog_ready  = 1'b1;
        voice_valid = (st == S_DONE);
        if (samp_tick) begin
          snap_ld = 1'b1;
          idx_n   = '0;
          st_n    = S_READ;
        end else begin
          st_n = S_IDLE;
        end
      end
      S_READ: begin
        busy   = 1'b1;
        lut_re = 1'b1;
        if (idx == LAST) st_n = S_DRAIN;
        else idx_n = idx + 1'b1;
      end
      S_DRAIN: begin
        busy = 1'b1;
        st_n = S_DONE;
      end
      default: st_n = S_IDLE;
    endcase
  end

  // State and issue index registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st  <= S_IDLE;
      idx <= '0;
    end else begin
      st  <= st_n;
      idx <= idx_n;
    end
  end

  // Capture pipeline trails the issue index by one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_en  <= 1'b0;
      cap_idx <= '0;
    end else begin
      cap_en  <= lut_re;
      cap_idx <= idx;
    end
  end

  // Land each returned word in its voice slot.
  always_ff @(posedge clk) begin
    if (!rst_n) vd <= '0;
    else if (cap_en) vd[cap_idx*WW +: WW] <= lut_rd;
  end

  // Freeze all phases at round start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NV; i++) snap[i] <= '0;
    end else if (snap_ld) begin
      for (int i = 0; i < NV; i++) snap[i] <= ph_addr[i*AW +: AW];
    end
  end

  // Sticky flag for ticks that land mid-round.
  always_ff @(posedge clk) begin
    if (!rst_n) overrun <= 1'b0;
    else if (samp_tick && busy) overrun <= 1'b1;
  end

  assign lut_ra     = snap[idx];
  assign lut_we     = prog_valid & prog_ready;
  assign lut_wa     = prog_addr;
  assign lut_wd     = prog_data;
  assign voice_data = vd;

endmodule

// File: doc/lut_voice_sched.md
Name: lut_voice_sched

Overview:
- Controller that time-multiplexes the single read port of the waveform LUT among NV DDS voices.
- Gates LUT reprogramming from the field-programming interface so a table write never lands inside a read round.
- Sits between the per-voice phase accumulators, the programming front-end and the LUT instance.
- Per sample tick, produces one registered LUT word per voice plus a completion strobe.

Parameters:
- NV, 4, number of voices sharing the LUT read port (≥1).
- WW, 12, LUT word width.
- DEPTH, 128, LUT words.
- AW, $clog2(DEPTH), LUT address width (derived, not overridden).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- samp_tick  in  1  one-cycle strobe that starts a read round.
- ph_addr  in  NV*AW  packed per-voice LUT addresses; voice i at [i*AW +: AW].
- prog_valid  in  1  programming write request.
- prog_addr  in  AW  programming write address.
- prog_data  in  WW  programming write data.
- prog_ready  out  1  write accepted this cycle when prog_valid&prog_ready.
- lut_re  out  1  LUT read enable.
- lut_ra  out  AW  LUT read address.
- lut_we  out  1  LUT write enable.
- lut_wa  out  AW  LUT write address.
- lut_wd  out  WW  LUT write data.
- lut_rd  in  WW  LUT read data; valid the cycle after lut_re.
- voice_data  out  NV*WW  registered per-voice samples; voice i at [i*WW +: WW].
- voice_valid  out  1  one-cycle pulse: all NV words of the round updated.
- busy  out  1  high while a round is in progress.
- overrun  out  1  sticky: samp_tick arrived while busy.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state IDLE.
  - voice_data, voice_valid, overrun, issue/capture counters and the phase snapshot all cleared to 0.
  - Takes effect mid-round: the round is aborted with no voice_valid.
- States:
  - IDLE: busy=0, prog_ready=1, lut_re=0.
    - samp_tick → snapshot all ph_addr into internal registers; go to READ with issue index 0.
  - READ: busy=1, prog_ready=0.
    - Each cycle: lut_re=1, lut_ra=snapshot[idx], idx++.
    - After idx=NV-1 is issued → DRAIN.
  - DRAIN: busy=1, prog_ready=0, lut_re=0. Captures the last voice's word → DONE.
  - DONE: busy=0, voice_valid=1 for exactly this cycle, prog_ready=1. Behaves as IDLE for inputs, so samp_tick here starts a new round immediately. Unconditionally leaves DONE next cycle (to READ on samp_tick, else IDLE).
- Capture: the word read for voice i (issued cycle c) is sampled from lut_rd at the end of cycle c+1 into voice_data slot i, via a capture index delayed one cycle from the issue index.
- Latency: samp_tick in cycle T0:
  - reads are issued in T1..T_NV;
  - voice_valid is high in T_{NV+2};
  - all NV words are visible in voice_data by T_{NV+2}.
- Round period: NV+2 cycles. The next samp_tick is legal in T_{NV+2}.
- Writes:
  - lut_we = prog_valid & prog_ready.
  - lut_wa = prog_addr and lut_wd = prog_data, combinational pass-through.
  - A held prog_valid during busy stalls; the requester must hold addr/data stable until accepted.
- samp_tick while busy (READ/DRAIN): ignored; overrun set to 1 and held until reset. The in-flight round is unaffected.
- samp_tick and prog_valid together in IDLE: the write is accepted that cycle and the round starts. The round's first read is one cycle later, so it sees the new data.
- voice_data holds its value between rounds. Slots update progressively during a round, so consumers must sample on voice_valid.
- NV=1: READ lasts one cycle. Index widths are at least 1 bit.

Decomposition:
- Shared package contains:
  - state encoding enum (IDLE, READ, DRAIN, DONE);
  - localparam for the index width, $clog2(NV) with a minimum of 1.
- No sub-module. The LUT itself is instantiated by the parent, not here.

Test Plan:
- Reset mid-round:
  - Stimulus: samp_tick, then rst_n=0 on T2.
  - Response: voice_data=0, busy=0, no voice_valid.
  - After release, a new samp_tick completes normally.
- Basic round:
  - Setup: NV=4, AW=7, ph_addr voice0..3 = 3,10,64,127; LUT preloaded q[a]=a+100.
  - Stimulus: samp_tick at T0.
  - Response: lut_ra = 3,10,64,127 in T1..T4; voice_valid only in T6; voice_data = 103,110,164,227.
- Phase snapshot:
  - Stimulus: change ph_addr in T1 mid-round.
  - Response: reads still use the T0 values; the next round uses the new ones.
- Write gating:
  - Stimulus: prog_valid held with addr=10, data=0x5A5 from T2 of a round.
  - Response: prog_ready=0 until T6; lut_we single cycle in T6.
  - Next round voice1 = 0x5A5.
- Simultaneous tick + write in IDLE:
  - Stimulus: samp_tick and a write to addr 3 = 0xFFF in the same cycle.
  - Response: voice0 reads 0xFFF.
- Back-to-back and overrun:
  - Stimulus: samp_tick in T0 and T6.
  - Response: two rounds, overrun stays 0.
  - Stimulus: samp_tick at T3.
  - Response: overrun=1 and sticky until reset; that round's result is unchanged.
